// File: rtl/shift_row_scheduler_if.sv
// rtl/shift_row_scheduler_if.sv - configuration handshake and line-buffer read bus of the row scheduler
interface shift_row_scheduler_if #(
  parameter int ROW_W = 10
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [3:0]       cfg_k;
  logic [3:0]       cfg_s;
  logic [ROW_W-1:0] cfg_rows;
  logic             row_rd_req;
  logic [ROW_W-1:0] row_rd_addr;
  logic             row_rd_ack;

  // master is the scheduler side; slave is the host / line buffer side
  modport master (
    input  cfg_valid, cfg_k, cfg_s, cfg_rows, row_rd_ack,
    output cfg_ready, row_rd_req, row_rd_addr
  );

  modport slave (
    output cfg_valid, cfg_k, cfg_s, cfg_rows, row_rd_ack,
    input  cfg_ready, row_rd_req, row_rd_addr
  );
endinterface

// File: rtl/shift_row_scheduler.sv
// rtl/shift_row_scheduler.sv - walks 3-row windows down a feature map, one shift pass per window
module shift_row_scheduler #(
  parameter int ROW_W = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  shift_row_scheduler_if.master  bus,
  output logic [3:0]             k_out,
  output logic [3:0]             s_out,
  output logic                   shift_start,
  input  logic                   re_fm_end,
  input  logic                   abort,
  output logic                   busy,
  output logic [ROW_W-1:0]       out_row_cnt,
  output logic                   done,
  output logic                   cfg_err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    LOAD  = 3'd2,
    SHIFT = 3'd3,
    NEXT  = 3'd4,
    FIN   = 3'd5
  } state_t;

  localparam logic [ROW_W:0] WIN_ROWS = (ROW_W+1)'(3);

  state_t           state;
  state_t           state_next;
  logic [ROW_W-1:0] row_idx;
  logic [ROW_W-1:0] rows_q;
  logic [3:0]       k_q;
  logic [3:0]       s_q;
  logic             cfg_err_q;
  logic             accept;
  logic             legal;
  logic             advance;

  assign accept = (state == IDLE) && bus.cfg_valid;
  assign legal  = ((bus.cfg_s == 4'd1) || (bus.cfg_s == 4'd2)) &&
                  (bus.cfg_k != 4'd0) && (bus.cfg_rows >= ROW_W'(3));

  // One extra bit so row_idx + s + 3 near the top of the range cannot wrap
  assign advance = ({1'b0, row_idx} + (ROW_W+1)'(s_q) + WIN_ROWS) <= {1'b0, rows_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && legal) state_next = REQ;
      REQ:     if (bus.row_rd_ack) state_next = LOAD;
      LOAD:    state_next = SHIFT;
      SHIFT:   if (re_fm_end) state_next = NEXT;
      NEXT:    state_next = advance ? REQ : FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // abort outranks a same-cycle ack or re_fm_end
    if (abort && (state != IDLE)) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_idx     <= '0;
      rows_q      <= '0;
      k_q         <= '0;
      s_q         <= '0;
      out_row_cnt <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      cfg_err_q <= accept && !legal;
      if (accept && legal) begin
        k_q         <= bus.cfg_k;
        s_q         <= bus.cfg_s;
        rows_q      <= bus.cfg_rows;
        row_idx     <= '0;
        out_row_cnt <= '0;
      end
      if ((state == NEXT) && !abort) begin
        out_row_cnt <= out_row_cnt + ROW_W'(1);
        if (advance) begin
          row_idx <= row_idx + ROW_W'(s_q);
        end
      end
    end
  end

  assign bus.cfg_ready   = (state == IDLE);
  assign bus.row_rd_req  = (state == REQ);
  assign bus.row_rd_addr = row_idx;
  assign busy            = (state != IDLE);
  assign shift_start     = (state == LOAD);
  assign done            = (state == FIN);
  assign cfg_err         = cfg_err_q;
  assign k_out           = k_q;
  assign s_out           = s_q;

endmodule

// File: tb/tb_shift_row_scheduler.sv
// tb/tb_shift_row_scheduler.sv - directed table-driven bench for shift_row_scheduler
module tb_shift_row_scheduler;
  localparam int ROW_W = 10;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       k_out;
  logic [3:0]       s_out;
  logic             shift_start;
  logic             re_fm_end;
  logic             abort;
  logic             busy;
  logic [ROW_W-1:0] out_row_cnt;
  logic             done;
  logic             cfg_err;

  int checks = 0;
  int errors = 0;

  shift_row_scheduler_if #(.ROW_W(ROW_W)) sif ();

  shift_row_scheduler #(.ROW_W(ROW_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (sif.master),
    .k_out       (k_out),
    .s_out       (s_out),
    .shift_start (shift_start),
    .re_fm_end   (re_fm_end),
    .abort       (abort),
    .busy        (busy),
    .out_row_cnt (out_row_cnt),
    .done        (done),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]       k;
    logic [3:0]       s;
    logic [9:0]       rows;
    logic             err;
    logic [3:0]       windows;
    logic [7:0][9:0]  addrs;
  } vec_t;

  localparam int NVEC = 10;
  vec_t vecs [NVEC];
  logic [3:0] prev_k = 4'd0;
  logic [3:0] prev_s = 4'd0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input int k, input int s, input int rows, input int err,
                         input int win, input int a0, input int a1, input int a2, input int a3);
    vecs[i]          = '0;
    vecs[i].k        = 4'(k);
    vecs[i].s        = 4'(s);
    vecs[i].rows     = 10'(rows);
    vecs[i].err      = 1'(err);
    vecs[i].windows  = 4'(win);
    vecs[i].addrs[0] = 10'(a0);
    vecs[i].addrs[1] = 10'(a1);
    vecs[i].addrs[2] = 10'(a2);
    vecs[i].addrs[3] = 10'(a3);
  endtask

  // Acts as line buffer (ack 2 cycles after req) and datapath (re_fm_end 4 cycles after shift_start)
  task automatic run_vec(input int idx, input vec_t v);
    int n_req = 0, n_start = 0, n_done = 0, n_err = 0, bad_addr = 0, busy_seen = 0;
    int req_age = 0, sh_age = -1, limit;
    bit fin = 1'b0;
    string tag;
    tag = $sformatf("v%0d", idx);
    limit = v.err ? 6 : 300;
    sif.cfg_k = v.k; sif.cfg_s = v.s; sif.cfg_rows = v.rows; sif.cfg_valid = 1'b1;
    tick();
    sif.cfg_valid = 1'b0;
    for (int c = 0; c < limit && !fin; c++) begin
      if (cfg_err) n_err++;
      if (busy) busy_seen++;
      if (sif.row_rd_req) begin
        if (req_age == 0) begin
          if (n_req < 8 && sif.row_rd_addr != v.addrs[n_req]) bad_addr++;
          n_req++;
        end
        sif.row_rd_ack = (req_age == 2);
        req_age++;
      end else begin
        req_age = 0;
        sif.row_rd_ack = 1'b0;
      end
      if (shift_start) begin
        n_start++;
        sh_age = 0;
      end else if (sh_age >= 0) begin
        sh_age++;
      end
      re_fm_end = (sh_age == 4);
      if (sh_age == 4) sh_age = -1;
      if (done) begin
        n_done++;
        fin = 1'b1;
      end
      tick();
    end
    sif.row_rd_ack = 1'b0;
    re_fm_end = 1'b0;
    chk({tag, "_cfg_err"}, n_err, v.err ? 1 : 0);
    chk({tag, "_reqs"}, n_req, v.err ? 0 : int'(v.windows));
    if (v.err) begin
      chk({tag, "_busy_seen"}, busy_seen, 0);
      chk({tag, "_k_out_held"}, int'(k_out), int'(prev_k));
      chk({tag, "_s_out_held"}, int'(s_out), int'(prev_s));
    end else begin
      chk({tag, "_timeout"}, int'(fin), 1);
      chk({tag, "_addr_seq_bad"}, bad_addr, 0);
      chk({tag, "_starts"}, n_start, int'(v.windows));
      chk({tag, "_dones"}, n_done, 1);
      chk({tag, "_done_one_cycle"}, int'(done), 0);
      chk({tag, "_busy_after"}, int'(busy), 0);
      chk({tag, "_out_row_cnt"}, int'(out_row_cnt), int'(v.windows));
      chk({tag, "_k_out"}, int'(k_out), int'(v.k));
      chk({tag, "_s_out"}, int'(s_out), int'(v.s));
      prev_k = v.k;
      prev_s = v.s;
    end
    tick();
  endtask

  initial begin
    int unstable, dn;
    reset = 1'b1; abort = 1'b0; re_fm_end = 1'b0;
    sif.cfg_valid = 1'b0; sif.cfg_k = '0; sif.cfg_s = '0; sif.cfg_rows = '0; sif.row_rd_ack = 1'b0;
    tick();
    tick();
    chk("rst_cfg_ready", int'(sif.cfg_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_req", int'(sif.row_rd_req), 0);
    chk("rst_addr", int'(sif.row_rd_addr), 0);
    chk("rst_start", int'(shift_start), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_cnt", int'(out_row_cnt), 0);
    chk("rst_k", int'(k_out), 0);
    reset = 1'b0;
    tick();

    set_vec(0, 3, 3, 8, 1, 0, 0, 0, 0, 0);
    set_vec(1, 3, 1, 5, 0, 3, 0, 1, 2, 0);
    set_vec(2, 2, 2, 8, 0, 3, 0, 2, 4, 0);
    set_vec(3, 3, 1, 2, 1, 0, 0, 0, 0, 0);
    set_vec(4, 2, 2, 9, 0, 4, 0, 2, 4, 6);
    set_vec(5, 0, 1, 5, 1, 0, 0, 0, 0, 0);
    set_vec(6, 1, 1, 3, 0, 1, 0, 0, 0, 0);
    set_vec(7, 5, 2, 4, 0, 1, 0, 0, 0, 0);
    set_vec(8, 4, 2, 3, 0, 1, 0, 0, 0, 0);
    set_vec(9, 15, 1, 6, 0, 4, 0, 1, 2, 3);
    for (int i = 0; i < NVEC; i++) begin
      run_vec(i, vecs[i]);
    end

    // Withheld ack with spurious re_fm_end, then abort racing re_fm_end in SHIFT
    sif.cfg_k = 4'd2; sif.cfg_s = 4'd1; sif.cfg_rows = 10'd6; sif.cfg_valid = 1'b1;
    tick();
    sif.cfg_valid = 1'b0;
    chk("seq_req0", int'(sif.row_rd_req), 1);
    chk("seq_addr0", int'(sif.row_rd_addr), 0);
    sif.row_rd_ack = 1'b1;
    tick();
    sif.row_rd_ack = 1'b0;
    chk("seq_start0", int'(shift_start), 1);
    tick();
    chk("seq_start0_pulse", int'(shift_start), 0);
    re_fm_end = 1'b1;
    tick();
    re_fm_end = 1'b0;
    tick();
    chk("seq_req1", int'(sif.row_rd_req), 1);
    chk("seq_addr1", int'(sif.row_rd_addr), 1);
    chk("seq_cnt1", int'(out_row_cnt), 1);
    unstable = 0;
    re_fm_end = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (!sif.row_rd_req || sif.row_rd_addr != 10'd1 || shift_start) unstable++;
    end
    re_fm_end = 1'b0;
    chk("seq_req_stable", unstable, 0);
    sif.row_rd_ack = 1'b1;
    tick();
    sif.row_rd_ack = 1'b0;
    chk("seq_start1", int'(shift_start), 1);
    tick();
    abort = 1'b1; re_fm_end = 1'b1;
    tick();
    abort = 1'b0; re_fm_end = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_cfg_ready", int'(sif.cfg_ready), 1);
    chk("abort_done", int'(done), 0);
    chk("abort_req", int'(sif.row_rd_req), 0);
    dn = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (done || busy) dn++;
    end
    chk("abort_quiet", dn, 0);
    sif.cfg_k = 4'd1; sif.cfg_s = 4'd1; sif.cfg_rows = 10'd3; sif.cfg_valid = 1'b1;
    tick();
    sif.cfg_valid = 1'b0;
    chk("restart_req", int'(sif.row_rd_req), 1);
    chk("restart_addr", int'(sif.row_rd_addr), 0);
    chk("restart_cnt", int'(out_row_cnt), 0);
    chk("restart_k", int'(k_out), 1);

    // Reset landing on the LOAD cycle
    sif.row_rd_ack = 1'b1;
    tick();
    sif.row_rd_ack = 1'b0;
    chk("load_start", int'(shift_start), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rload_start", int'(shift_start), 0);
    chk("rload_busy", int'(busy), 0);
    chk("rload_cfg_ready", int'(sif.cfg_ready), 1);
    chk("rload_req", int'(sif.row_rd_req), 0);
    chk("rload_done", int'(done), 0);
    chk("rload_cfg_err", int'(cfg_err), 0);
    chk("rload_cnt", int'(out_row_cnt), 0);
    chk("rload_k", int'(k_out), 0);
    chk("rload_s", int'(s_out), 0);
    tick();
    chk("rload_no_done", int'(done), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_row_scheduler.md
SHIFT_ROW_SCHEDULER -- requirements
Module: shift_row_scheduler

Interface
REQ-001 Parameter ROW_W, default 10, width of the row index, row count and output-row counter.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cfg_valid  input  1  configuration offer; accepted when cfg_valid && cfg_ready.
REQ-005 cfg_ready  output  1  high only in IDLE.
REQ-006 cfg_k  input  4  horizontal shift count per row window, forwarded to the shift datapath.
REQ-007 cfg_s  input  4  stride; legal values 1 and 2 only.
REQ-008 cfg_rows  input  ROW_W  input feature-map rows; legal range is 3 or more.
REQ-009 k_out, s_out  output  4 each  registered copies of the accepted cfg_k and cfg_s, held stable until the next accept.
REQ-010 row_rd_req  output  1  request to the line buffer for the 3-row window starting at row_rd_addr.
REQ-011 row_rd_addr  output  ROW_W  top row of the requested window.
REQ-012 row_rd_ack  input  1  line buffer has driven row_regs_1..3 valid in this cycle.
REQ-013 shift_start  output  1  one-cycle load/start pulse to the shift datapath.
REQ-014 re_fm_end  input  1  shift datapath finished the current window.
REQ-015 abort  input  1  abandon the current frame.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 out_row_cnt  output  ROW_W  number of windows completed in the current frame.
REQ-018 done  output  1  one-cycle pulse at frame completion.
REQ-019 cfg_err  output  1  one-cycle pulse when an illegal configuration is rejected.

Function
REQ-020 The FSM SHALL have the states IDLE, REQ, LOAD, SHIFT, NEXT and FIN.
- IDLE: on accept with legal cfg (s in {1,2}, k != 0, rows >= 3), latch cfg, set row_idx to 0, clear out_row_cnt, go to REQ.
- IDLE: on accept with illegal cfg, pulse cfg_err the next cycle, stay in IDLE, leave k_out and s_out unchanged.
REQ-021 REQ: row_rd_req = 1 and row_rd_addr = row_idx, held stable until row_rd_ack; on the ack cycle go to LOAD.
REQ-022 An ack received outside REQ SHALL be ignored.
REQ-023 LOAD: shift_start = 1 for exactly this one cycle, then go to SHIFT; shift_start is 0 in every other state.
REQ-024 SHIFT: wait for re_fm_end; on re_fm_end go to NEXT.
REQ-025 re_fm_end received in any state other than SHIFT SHALL be ignored.
REQ-026 NEXT: increment out_row_cnt; if row_idx + s + 3 <= rows, set row_idx += s and go to REQ; otherwise go to FIN.
REQ-027 The NEXT comparison SHALL be computed at ROW_W+1 bits so it has no wrap-around.
REQ-028 FIN: done = 1 for one cycle, then go to IDLE; out_row_cnt holds its value until the next accept.
REQ-029 Expected windows per frame = floor((rows-3)/s)+1.
REQ-030 Minimum per-window latency, ack cycle to next row_rd_req: LOAD(1) + SHIFT (k+1 cycles, as timed by the datapath) + NEXT(1).
REQ-031 abort in any non-IDLE state SHALL force IDLE on the next edge.
REQ-032 On the abort edge, row_rd_req and shift_start SHALL be deasserted and done SHALL not pulse.
REQ-033 abort has priority over simultaneous row_rd_ack or re_fm_end.
REQ-034 abort in IDLE SHALL have no effect.
REQ-035 cfg_valid outside IDLE SHALL be ignored, with cfg_ready = 0.

Reset
REQ-036 reset SHALL place the FSM in IDLE and drive cfg_ready=1, busy=0, row_rd_req=0, row_rd_addr=0, shift_start=0, done=0, cfg_err=0, out_row_cnt=0, k_out=0, s_out=0.
REQ-037 reset asserted mid-frame SHALL take effect on the next edge with the same priority as abort, and no done pulse.

Verification
REQ-038 cfg k=3, s=1, rows=5; ack 2 cycles after each req; re_fm_end 4 cycles after each shift_start -> row_rd_addr sequence 0,1,2, three shift_start pulses, done once, out_row_cnt=3.
REQ-039 cfg k=2, s=2, rows=8 -> addr sequence 0,2,4; done after 3 windows (floor(5/2)+1); rows=9 -> addr 0,2,4,6, 4 windows.
REQ-040 cfg s=3 or rows=2 or k=0 -> cfg_err pulses once, busy stays 0, k_out/s_out unchanged, no row_rd_req.
REQ-041 row_rd_ack withheld 10 cycles -> row_rd_req and row_rd_addr stable throughout; spurious re_fm_end during REQ ignored.
REQ-042 abort coincident with re_fm_end in SHIFT -> IDLE next cycle, no done, cfg_ready=1, new cfg accepted with row_idx restarting at 0.
REQ-043 reset in LOAD cycle -> shift_start low next cycle, all outputs at reset values.
